// File: rtl/lifo_param.sv
// ---------------------------------------------------------------------------
// lifo_param
// Parametrised synchronous last-in-first-out stack on a single clock.
//
// Parameters
//    WIDTH     data word width in bits
//    DEPTH     number of entries (need not be a power of two)
//    AF_LEVEL  almost_full asserts when count >= AF_LEVEL
//    AE_LEVEL  almost_empty asserts when count <= AE_LEVEL
//
// Ports
//    clk           rising-edge clock
//    rst           synchronous active-high reset
//    clear         synchronous flush, empties the stack
//    push          write data_in onto the top of the stack
//    pop           remove the top of the stack into data_out
//    data_in       push data
//    data_out      last popped word, registered, holds between pops
//    count         current occupancy, 0..DEPTH
//    empty         count == 0
//    full          count == DEPTH
//    almost_full   count >= AF_LEVEL
//    almost_empty  count <= AE_LEVEL
//    overflow      one-cycle pulse after a rejected push
//    underflow     one-cycle pulse after a rejected pop
// ---------------------------------------------------------------------------
module lifo_param #(
   parameter int WIDTH    = 16,
   parameter int DEPTH    = 16,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clear,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           data_in,
   output logic [WIDTH-1:0]           data_out,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       empty,
   output logic                       full,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // Reject inconsistent threshold settings at elaboration time.
   if (!(AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH)) begin : g_param_check
      $fatal(1, "lifo_param: require AE_LEVEL < AF_LEVEL <= DEPTH");
   end

   logic [WIDTH-1:0] mem [0:DEPTH-1];
   logic [AW-1:0]    top_addr;
   logic [AW-1:0]    wr_addr;
   logic             wr_en;

   // Flags are pure decodes of the registered count, so they only move
   // after a clock edge and never glitch on input activity.
   assign empty        = (count == '0);
   assign full         = (count == CW'(DEPTH));
   assign almost_full  = (count >= CW'(AF_LEVEL));
   assign almost_empty = (count <= CW'(AE_LEVEL));

   // The top entry lives at count-1; it is only read when the stack is
   // not empty, so the wrap at count==0 is harmless.
   assign top_addr = AW'(count - 1'b1);

   // Decide where data_in lands. A push alongside a pop either replaces
   // the top (stack not empty) or lands in slot 0 (stack empty, the pop is
   // the part that gets rejected). A lone push needs a free slot.
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = AW'(count);
      if (!rst && !clear && push) begin
         if (pop) begin
            wr_en = 1'b1;
            if (!empty) begin
               wr_addr = top_addr;
            end
         end else begin
            wr_en = !full;
         end
      end
   end

   // Storage has no reset; only the write port touches it.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= data_in;
      end
   end

   // Occupancy, read data and error pulses. Error pulses default low every
   // cycle so they last exactly one cycle after the offending edge.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count     <= '0;
         data_out  <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
         case ({push, pop})
            2'b10: begin
               if (full) begin
                  overflow <= 1'b1;
               end else begin
                  count <= count + 1'b1;
               end
            end
            2'b01: begin
               if (empty) begin
                  underflow <= 1'b1;
               end else begin
                  data_out <= mem[top_addr];
                  count    <= count - 1'b1;
               end
            end
            2'b11: begin
               if (empty) begin
                  count     <= CW'(1);
                  underflow <= 1'b1;
               end else begin
                  data_out <= mem[top_addr];
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lifo_param.sv
// ---------------------------------------------------------------------------
// tb_lifo_param
// Self-checking bench for lifo_param (WIDTH=16, DEPTH=16, defaults for the
// thresholds). A queue-based stack model predicts every cycle's outputs;
// predictions go into a scoreboard queue that an independent monitor drains
// on the falling edge and compares against the DUT.
// ---------------------------------------------------------------------------
module tb_lifo_param;

   localparam int WIDTH = 16;
   localparam int DEPTH = 16;
   localparam int AF    = DEPTH - 2;
   localparam int AE    = 2;
   localparam int CW    = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             rst;
   logic             clear;
   logic             push;
   logic             pop;
   logic [WIDTH-1:0] data_in;
   logic [WIDTH-1:0] data_out;
   logic [CW-1:0]    count;
   logic             empty;
   logic             full;
   logic             almost_full;
   logic             almost_empty;
   logic             overflow;
   logic             underflow;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [WIDTH-1:0] dout;
      int               cnt;
      bit               ovf;
      bit               unf;
   } exp_t;

   exp_t             expq[$];
   logic [WIDTH-1:0] model[$];
   logic [WIDTH-1:0] m_dout;
   bit               m_ovf;
   bit               m_unf;

   lifo_param #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .AF_LEVEL (AF),
      .AE_LEVEL (AE)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .clear        (clear),
      .push         (push),
      .pop          (pop),
      .data_in      (data_in),
      .data_out     (data_out),
      .count        (count),
      .empty        (empty),
      .full         (full),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   always #5 clk = ~clk;

   // One comparison: count it, and report a mismatch with both values.
   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs, advance the stack model across the edge and
   // queue the outputs the DUT must show after that edge.
   task automatic applyStimulus(input bit r, input bit c, input bit pu,
                                input bit po, input logic [WIDTH-1:0] d);
      rst     = r;
      clear   = c;
      push    = pu;
      pop     = po;
      data_in = d;
      @(posedge clk);
      m_ovf = 1'b0;
      m_unf = 1'b0;
      if (r || c) begin
         model.delete();
         m_dout = '0;
      end else if (pu && po) begin
         if (model.size() == 0) begin
            model.push_back(d);
            m_unf = 1'b1;
         end else begin
            m_dout = model[$];
            model[model.size() - 1] = d;
         end
      end else if (pu) begin
         if (model.size() == DEPTH) m_ovf = 1'b1;
         else model.push_back(d);
      end else if (po) begin
         if (model.size() == 0) m_unf = 1'b1;
         else m_dout = model.pop_back();
      end
      expq.push_back('{m_dout, model.size(), m_ovf, m_unf});
      @(negedge clk);
   endtask

   // Monitor: each falling edge, compare the DUT against the oldest
   // outstanding prediction. Flags are re-derived from the predicted size.
   always @(negedge clk) begin
      exp_t e;
      if (expq.size() > 0) begin
         e = expq.pop_front();
         checkOutput("data_out",     32'(data_out),     32'(e.dout));
         checkOutput("count",        32'(count),        32'(e.cnt));
         checkOutput("empty",        32'(empty),        32'(e.cnt == 0));
         checkOutput("full",         32'(full),         32'(e.cnt == DEPTH));
         checkOutput("almost_full",  32'(almost_full),  32'(e.cnt >= AF));
         checkOutput("almost_empty", 32'(almost_empty), 32'(e.cnt <= AE));
         checkOutput("overflow",     32'(overflow),     32'(e.ovf));
         checkOutput("underflow",    32'(underflow),    32'(e.unf));
      end
   end

   // Safety net in case the stimulus process ever stalls.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int phase;
      int wait_cycles;
      m_dout  = '0;
      rst     = 1'b1;
      clear   = 1'b0;
      push    = 1'b0;
      pop     = 1'b0;
      data_in = '0;
      @(negedge clk);

      // Reset state
      applyStimulus(1, 0, 0, 0, 16'h0);
      applyStimulus(1, 0, 0, 0, 16'h0);

      // Fill 0..15, overflow with 16, then drain
      for (int i = 0; i <= DEPTH; i++) applyStimulus(0, 0, 1, 0, 16'(i));
      for (int i = 0; i < DEPTH; i++) applyStimulus(0, 0, 0, 1, 16'h0);

      // Underflow on empty, then push+pop on empty, then pop it back
      applyStimulus(0, 0, 0, 1, 16'h0);
      applyStimulus(0, 0, 1, 1, 16'hAAAA);
      applyStimulus(0, 0, 0, 1, 16'h0);

      // Replace top: push 1,2,3; push+pop 9; pop three
      for (int i = 1; i <= 3; i++) applyStimulus(0, 0, 1, 0, 16'(i));
      applyStimulus(0, 0, 1, 1, 16'h9);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 16'h0);

      // Replace while full
      for (int i = 0; i < DEPTH; i++) applyStimulus(0, 0, 1, 0, 16'(16'h100 + i));
      applyStimulus(0, 0, 1, 1, 16'hBEEF);
      applyStimulus(0, 0, 1, 1, 16'hCAFE);
      applyStimulus(0, 0, 0, 1, 16'h0);

      // Clear with a simultaneous push after five words
      applyStimulus(1, 0, 0, 0, 16'h0);
      for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 0, 16'(16'h50 + i));
      applyStimulus(0, 0, 0, 1, 16'h0);
      applyStimulus(0, 1, 1, 0, 16'h7777);
      applyStimulus(0, 0, 0, 1, 16'h0);

      // Reset in the middle of a pop burst, then refill and drain
      for (int i = 0; i < 6; i++) applyStimulus(0, 0, 1, 0, 16'(16'h60 + i));
      applyStimulus(0, 0, 0, 1, 16'h0);
      applyStimulus(0, 0, 0, 1, 16'h0);
      applyStimulus(1, 0, 0, 1, 16'h0);
      for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 0, 16'(16'h70 + i));
      for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 1, 16'h0);

      // Randomised traffic alternating push-heavy and pop-heavy phases so
      // both boundaries are visited repeatedly.
      for (int i = 0; i < 800; i++) begin
         phase = (i / 40) % 2;
         applyStimulus(($urandom_range(0, 199) == 0),
                       ($urandom_range(0, 99) == 0),
                       (phase == 0) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 3),
                       (phase == 0) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8),
                       16'($urandom));
      end

      rst  = 1'b0;
      push = 1'b0;
      pop  = 1'b0;
      wait_cycles = 0;
      while (expq.size() > 0 && wait_cycles < 10) begin
         @(negedge clk);
         wait_cycles++;
      end
      if (expq.size() > 0) begin
         errors++;
         $display("[TB] FAIL drain: got %0d pending expected 0", expq.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
